// File: rtl/spi_flash_read_pkg.sv
// Shared definitions for the SPI PROM masters: opcodes, FSM encoding and SPI mode-0 timing.
package spi_flash_read_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDID      = 8'h9F;

    // Mode 0: SPICLK idles low, data launched on falling and captured on rising edges.
    localparam logic SCLK_IDLE  = 1'b0;
    localparam int   ADDR_BYTES = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_CS_HOLD,
        ST_GAP
    } state_e;

    // Address byte idx, 0 = most significant (first on the wire).
    function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            2'd0:    b = a[23:16];
            2'd1:    b = a[15:8];
            2'd2:    b = a[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_read_byte_xfer.sv
// spi_byte_xfer: full-duplex 8-bit mode-0 shifter with SPICLK phase generation.
// A load accepted while ready chains the next byte with no gap in the SPICLK train.
module spi_byte_xfer
    import spi_flash_read_pkg::*;
#(
    parameter int CLK_DIV_HALF = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       ready
);

    localparam int DIV_W = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;

    logic             active_q, active_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       tx_q, tx_d;
    logic [6:0]       rx_q, rx_d;
    logic             tick, last;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            sclk_q   <= SCLK_IDLE;
            mosi_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= 3'd0;
            tx_q     <= 7'd0;
            rx_q     <= 7'd0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    // byte_done/ready flag the cycle whose closing edge is the 8th rise / 8th fall.
    always_comb begin
        tick      = active_q && (div_q == DIV_W'(CLK_DIV_HALF - 1));
        last      = (bit_q == 3'd7);
        byte_done = tick && !sclk_q && last;
        ready     = !active_q || (tick && sclk_q && last);
        rx_byte   = {rx_q, miso};

        active_d = active_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        div_d    = div_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;

        if (active_q) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                sclk_d = ~sclk_q;
                if (!sclk_q) begin
                    rx_d = {rx_q[5:0], miso};
                end else if (!last) begin
                    bit_d  = bit_q + 3'd1;
                    mosi_d = tx_q[6];
                    tx_d   = {tx_q[5:0], 1'b0};
                end else begin
                    active_d = 1'b0;
                end
            end
        end

        if (load && ready) begin
            active_d = 1'b1;
            sclk_d   = SCLK_IDLE;
            div_d    = '0;
            bit_d    = 3'd0;
            tx_d     = tx_byte[6:0];
            mosi_d   = tx_byte[7];
        end
    end

    assign sclk = sclk_q;
    assign mosi = mosi_q;

endmodule

// File: rtl/spi_flash_read.sv
// SPI READ engine for the serial PROM: opcode + 24-bit address, then byte_count bytes out.
// Define FAST_READ_EN to use FAST_READ (0Bh) with one dummy byte after the address.
module spi_flash_read
    import spi_flash_read_pkg::*;
#(
    parameter int CLK_DIV_HALF = 2,
    parameter int CS_GAP       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [7:0]  byte_count,
    output logic        busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        SPICLK,
    output logic        SPIMOSI,
    input  logic        SPIMISO,
    output logic        chip_select
);

`ifdef FAST_READ_EN
    localparam logic [7:0] OPCODE    = OP_FAST_READ;
    localparam logic       HAS_DUMMY = 1'b1;
`else
    localparam logic [7:0] OPCODE    = OP_READ;
    localparam logic       HAS_DUMMY = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  hdr_q, hdr_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic        cs_q, cs_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic        x_load, x_done, x_ready, x_sclk, x_mosi;
    logic [7:0]  x_tx, x_rx;
    logic        accept, half_end, gap_end;

    assign accept   = start && (byte_count != 8'd0);
    assign half_end = (cnt_q == 8'(CLK_DIV_HALF - 1));
    assign gap_end  = (cnt_q == 8'(CS_GAP - 1));

    spi_byte_xfer #(.CLK_DIV_HALF(CLK_DIV_HALF)) u_xfer (
        .clk       (clk),
        .reset     (reset),
        .load      (x_load),
        .tx_byte   (x_tx),
        .miso      (SPIMISO),
        .sclk      (x_sclk),
        .mosi      (x_mosi),
        .rx_byte   (x_rx),
        .byte_done (x_done),
        .ready     (x_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            hdr_q      <= 2'd0;
            addr_q     <= 24'd0;
            byte_cnt_q <= 8'd0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (accept)   state_d = ST_CS_SETUP;
            ST_CS_SETUP: if (half_end) state_d = ST_CMD;
            ST_CMD:      if (x_ready)  state_d = ST_ADDR;
            ST_ADDR:     if (x_ready && hdr_q == 2'(ADDR_BYTES))
                             state_d = HAS_DUMMY ? ST_DUMMY : ST_DATA;
            ST_DUMMY:    if (x_ready)  state_d = ST_DATA;
            ST_DATA:     if (x_ready && byte_cnt_q == 8'd0) state_d = ST_CS_HOLD;
            ST_CS_HOLD:  if (half_end) state_d = ST_GAP;
            ST_GAP:      if (gap_end)  state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // byte_cnt_q holds bytes still to be loaded into the shifter, not bytes received.
    always_comb begin
        cnt_d      = cnt_q + 8'd1;
        hdr_d      = hdr_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        cs_d       = cs_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        x_load     = 1'b0;
        x_tx       = 8'h00;
        rd_valid_d = x_done && (state_q == ST_DATA);
        rd_data_d  = rd_valid_d ? x_rx : rd_data_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (accept) begin
                    cs_d       = 1'b0;
                    busy_d     = 1'b1;
                    addr_d     = addr;
                    byte_cnt_d = byte_count;
                    hdr_d      = 2'd0;
                end
            end
            ST_CS_SETUP: begin
                if (half_end) begin
                    x_load = 1'b1;
                    x_tx   = OPCODE;
                end
            end
            ST_CMD: begin
                if (x_ready) begin
                    x_load = 1'b1;
                    x_tx   = addr_byte(addr_q, 2'd0);
                    hdr_d  = 2'd1;
                end
            end
            ST_ADDR: begin
                if (x_ready) begin
                    x_load = 1'b1;
                    if (hdr_q == 2'(ADDR_BYTES)) begin
                        if (!HAS_DUMMY) byte_cnt_d = byte_cnt_q - 8'd1;
                    end else begin
                        x_tx  = addr_byte(addr_q, hdr_q);
                        hdr_d = hdr_q + 2'd1;
                    end
                end
            end
            ST_DUMMY: begin
                if (x_ready) begin
                    x_load     = 1'b1;
                    byte_cnt_d = byte_cnt_q - 8'd1;
                end
            end
            ST_DATA: begin
                if (x_ready) begin
                    if (byte_cnt_q != 8'd0) begin
                        x_load     = 1'b1;
                        byte_cnt_d = byte_cnt_q - 8'd1;
                    end else begin
                        cnt_d = 8'd0;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (half_end) begin
                    cs_d   = 1'b1;
                    done_d = 1'b1;
                    cnt_d  = 8'd0;
                end
            end
            ST_GAP: begin
                if (gap_end) busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy        = busy_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign done        = done_q;
    assign chip_select = cs_q;
    assign SPICLK      = x_sclk;
    // The shifter is not yet loaded during CS_SETUP, so present the opcode MSB directly.
    assign SPIMOSI     = (state_q == ST_CS_SETUP) ? OPCODE[7] : x_mosi;

endmodule

// File: tb/tb_spi_flash_read.sv
// Bench: three DUTs (CLK_DIV_HALF = 2, 1, 3) in lockstep against a behavioural serial PROM model.
module tb_spi_flash_read;

`ifdef FAST_READ_EN
    localparam logic [7:0] EXP_OP = 8'h0B;
    localparam int         HDR    = 40;
`else
    localparam logic [7:0] EXP_OP = 8'h03;
    localparam int         HDR    = 32;
`endif
    localparam int NI  = 3;
    localparam int CSG = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [23:0] addr = 24'd0;
    logic [7:0]  byte_count = 8'd0;
    logic [NI-1:0] busy_w, rdv_w, done_w, sclk_w, mosi_w, cs_w;
    logic [NI-1:0] miso_r = '0;
    logic [NI-1:0][7:0] rdd_w;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_flash_read #(.CLK_DIV_HALF(g == 0 ? 2 : (g == 1 ? 1 : 3)), .CS_GAP(CSG)) dut (
            .clk(clk), .reset(reset), .start(start), .addr(addr), .byte_count(byte_count),
            .busy(busy_w[g]), .rd_data(rdd_w[g]), .rd_valid(rdv_w[g]), .done(done_w[g]),
            .SPICLK(sclk_w[g]), .SPIMOSI(mosi_w[g]), .SPIMISO(miso_r[g]), .chip_select(cs_w[g]));
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] mem_xor = 8'h00;

    int nrise[NI], cs_fall_t[NI], first_rise_t[NI], last_rise_t[NI], last_fall_t[NI];
    int cs_rise_t[NI], done_t[NI], busy_fall_t[NI], min_per[NI], max_per[NI];
    int ncsfall[NI], ndone[NI], vld_err[NI], idle_err[NI], mosi_err[NI], act[NI];
    logic [31:0] hdr_sh[NI];
    logic [23:0] maddr[NI];
    logic [7:0]  hdr_bytes[NI][$];
    logic [7:0]  rdq[NI][$];
    logic [NI-1:0] p_sclk = '0, p_cs = '1, p_busy = '0;

    function automatic int half_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
    endfunction

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ mem_xor;
    endfunction

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NI; i++) begin
            nrise[i] = 0; hdr_sh[i] = 0; maddr[i] = 0;
            hdr_bytes[i].delete(); rdq[i].delete();
            cs_fall_t[i] = -1; first_rise_t[i] = -1; last_rise_t[i] = -1; last_fall_t[i] = -1;
            cs_rise_t[i] = -1; done_t[i] = -1; busy_fall_t[i] = -1;
            min_per[i] = 1 << 30; max_per[i] = 0;
            ncsfall[i] = 0; ndone[i] = 0; vld_err[i] = 0; idle_err[i] = 0; mosi_err[i] = 0; act[i] = 0;
        end
    endtask

    // One clock: sample just after the edge, play the PROM, collect bus observations.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            logic exp_v;
            logic [7:0] b;
            int k;
            exp_v = 1'b0;
            if (p_cs[i] && !cs_w[i]) begin ncsfall[i]++; cs_fall_t[i] = cyc; nrise[i] = 0; end
            if (!p_cs[i] && cs_w[i]) cs_rise_t[i] = cyc;
            if (cs_w[i] && sclk_w[i]) idle_err[i]++;
            if (!cs_w[i] && sclk_w[i] && !p_sclk[i]) begin
                if (nrise[i] == 0) first_rise_t[i] = cyc;
                else begin
                    k = cyc - last_rise_t[i];
                    if (k < min_per[i]) min_per[i] = k;
                    if (k > max_per[i]) max_per[i] = k;
                end
                last_rise_t[i] = cyc;
                if (nrise[i] < HDR) begin
                    hdr_sh[i] = {hdr_sh[i][30:0], mosi_w[i]};
                    if ((nrise[i] + 1) % 8 == 0) hdr_bytes[i].push_back(hdr_sh[i][7:0]);
                end else if (mosi_w[i]) mosi_err[i]++;
                nrise[i]++;
                if (nrise[i] == 32) maddr[i] = hdr_sh[i][23:0];
                if (nrise[i] > HDR && (nrise[i] - HDR) % 8 == 0) exp_v = 1'b1;
            end
            if (!cs_w[i] && !sclk_w[i] && p_sclk[i]) begin
                last_fall_t[i] = cyc;
                if (nrise[i] >= HDR) begin
                    k = nrise[i] - HDR;
                    b = mem_byte(maddr[i] + 24'(k / 8));
                    miso_r[i] = b[7 - (k % 8)];
                end
            end
            if (rdv_w[i] !== exp_v) vld_err[i]++;
            if (rdv_w[i]) rdq[i].push_back(rdd_w[i]);
            if (done_w[i]) begin ndone[i]++; done_t[i] = cyc; end
            if (p_busy[i] && !busy_w[i]) busy_fall_t[i] = cyc;
            if (busy_w[i] || !cs_w[i] || sclk_w[i]) act[i]++;
        end
        p_sclk = sclk_w; p_cs = cs_w; p_busy = busy_w;
    endtask

    task automatic verify(input logic [23:0] a, input int n);
        for (int i = 0; i < NI; i++) begin
            int h;
            h = half_of(i);
            check("cs_windows", i, ncsfall[i], 1);
            check("done_count", i, ndone[i], 1);
            check("strobes", i, rdq[i].size(), n);
            for (int j = 0; j < n && j < rdq[i].size(); j++)
                check("rd_data", i, 32'(rdq[i][j]), 32'(mem_byte(a + 24'(j))));
            check("hdr_len", i, hdr_bytes[i].size(), HDR / 8);
            if (hdr_bytes[i].size() >= HDR / 8) begin
                check("opcode", i, 32'(hdr_bytes[i][0]), 32'(EXP_OP));
                check("addr_hi", i, 32'(hdr_bytes[i][1]), 32'(a[23:16]));
                check("addr_mid", i, 32'(hdr_bytes[i][2]), 32'(a[15:8]));
                check("addr_lo", i, 32'(hdr_bytes[i][3]), 32'(a[7:0]));
`ifdef FAST_READ_EN
                check("dummy", i, 32'(hdr_bytes[i][4]), 32'h0);
`endif
            end
            check("valid_timing", i, vld_err[i], 0);
            check("sclk_idle", i, idle_err[i], 0);
            check("mosi_data_zero", i, mosi_err[i], 0);
            check("period_min", i, min_per[i], 2 * h);
            check("period_max", i, max_per[i], 2 * h);
            check("cs_setup", i, first_rise_t[i] - cs_fall_t[i], 2 * h);
            check("cs_hold", i, cs_rise_t[i] - last_fall_t[i], h);
            check("done_at_cs", i, done_t[i], cs_rise_t[i]);
            check("gap", i, busy_fall_t[i] - done_t[i], CSG);
        end
    endtask

    task automatic run_xfer(input logic [23:0] a, input int n, input int poke);
        clear_stats();
        addr = a; byte_count = 8'(n); start = 1'b1;
        step();
        start = 1'b0;
        check("entry_cs", -1, 32'(cs_w), 32'h0);
        check("entry_busy", -1, 32'(busy_w), 32'h7);
        check("entry_mosi", -1, 32'(mosi_w), 32'h0);
        addr = 24'($urandom); byte_count = 8'($urandom);
        for (int t = 1; t < 6000 && busy_w != '0; t++) begin
            if (t == poke) start = 1'b1;
            step();
            start = 1'b0;
        end
        check("busy_timeout", -1, 32'(busy_w), 32'h0);
        verify(a, n);
    endtask

    initial begin
        clear_stats();
        reset = 1'b1;
        repeat (3) step();
        check("rst_busy", -1, 32'(busy_w), 32'h0);
        check("rst_cs", -1, 32'(cs_w), 32'h7);
        check("rst_sclk", -1, 32'(sclk_w), 32'h0);
        check("rst_mosi", -1, 32'(mosi_w), 32'h0);
        check("rst_valid", -1, 32'(rdv_w | done_w), 32'h0);
        check("rst_data", -1, 32'(rdd_w), 32'h0);
        reset = 1'b0;
        step();

        run_xfer(24'h000010, 4, 0);

        clear_stats();
        addr = 24'h000100; byte_count = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (99) step();
        for (int i = 0; i < NI; i++) check("zero_count_idle", i, act[i], 0);

        run_xfer(24'h00ABCD, 5, 5);

        clear_stats();
        addr = 24'h123456; byte_count = 8'd4; start = 1'b1;
        step();
        start = 1'b0;
        repeat (59) step();
        for (int i = 0; i < NI; i++) check("in_addr_phase", i, 32'(nrise[i] >= 8 && nrise[i] < 32), 32'h1);
        reset = 1'b1;
        step();
        check("abort_cs", -1, 32'(cs_w), 32'h7);
        check("abort_sclk", -1, 32'(sclk_w), 32'h0);
        check("abort_busy", -1, 32'(busy_w), 32'h0);
        check("abort_mosi", -1, 32'(mosi_w), 32'h0);
        check("abort_data", -1, 32'(rdd_w), 32'h0);
        reset = 1'b0;
        repeat (30) step();
        for (int i = 0; i < NI; i++) begin
            check("abort_no_done", i, ndone[i], 0);
            check("abort_no_valid", i, rdq[i].size(), 0);
        end
        run_xfer(24'h00C0DE, 3, 0);

        run_xfer(24'hFFFFFE, 3, 0);

        repeat (6) begin
            mem_xor = 8'($urandom);
            run_xfer(24'($urandom), $urandom_range(1, 8), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
